id_ex_pipe_buffer: RTL and testbench

Parametrised decode-to-execute pipeline buffer that replaces the fixed single-entry ID/EX register. It carries a packed control/immediate/PC payload plus source-register indices and operand values through a DEPTH-entry elastic buffer with valid/ready handshake. Stall (backpressure) is separated from flush, so a stall holds instructions instead of zeroing them. Held operands are patched in place from the writeback port so a stalled instruction never issues with a stale register value.

---
 rtl/id_ex_pipe_buffer.sv | 135 +++++++++++++
 tb/tb_id_ex_pipe_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_buffer.sv
// Decode-to-execute elastic buffer: DEPTH-entry FIFO with valid/ready handshake,
// flush, writeback operand patching of held entries and a bubble counter.
module id_ex_pipe_buffer #(
    parameter int XLEN   = 32,
    parameter int CTL_W  = 96,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [XLEN-1:0]   in_rd1,
    input  logic [XLEN-1:0]   in_rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [XLEN-1:0]   out_rd1,
    output logic [XLEN-1:0]   out_rd2,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [2:0]        count,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      DEPTH_C  = 3'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

    logic [CTL_W-1:0]  ctl_q [DEPTH];
    logic [REG_AW-1:0] rs1_q [DEPTH];
    logic [REG_AW-1:0] rs2_q [DEPTH];
    logic [XLEN-1:0]   rd1_q [DEPTH];
    logic [XLEN-1:0]   rd2_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [2:0]        count_q;
    logic [CNT_W-1:0]  bubble_q;

    logic push;
    logic pop;
    logic wb_hit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // in_ready depends only on stored occupancy, never on out_ready.
    assign in_ready  = !rst && (count_q < DEPTH_C);
    assign out_valid = (count_q != 3'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wb_hit    = wb_we && (wb_rd != '0);

    // An empty buffer presents an all-zero bubble so nothing downstream acts on it.
    assign out_ctl    = out_valid ? ctl_q[head_q] : '0;
    assign out_rs1    = out_valid ? rs1_q[head_q] : '0;
    assign out_rs2    = out_valid ? rs2_q[head_q] : '0;
    assign out_rd1    = out_valid ? rd1_q[head_q] : '0;
    assign out_rd2    = out_valid ? rd2_q[head_q] : '0;
    assign count      = count_q;
    assign bubble_cnt = bubble_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            vld_q    <= '0;
            bubble_q <= '0;
            // NOTE: the storage array is cleared on reset on purpose; it is small
            // and a clean reset state keeps stale operands out of the datapath.
            for (int i = 0; i < DEPTH; i++) begin
                ctl_q[i] <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                rd1_q[i] <= '0;
                rd2_q[i] <= '0;
            end
        end else begin
            if (out_ready && !out_valid && (bubble_q != '1))
                bubble_q <= bubble_q + CNT_W'(1);

            if (flush) begin
                count_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                vld_q   <= '0;
            end else begin
                // Patch held operands; the entry leaving this cycle is already consumed.
                for (int i = 0; i < DEPTH; i++) begin
                    if (vld_q[i] && wb_hit && !(pop && head_q == PW'(i))) begin
                        if (rs1_q[i] == wb_rd) rd1_q[i] <= wb_data;
                        if (rs2_q[i] == wb_rd) rd2_q[i] <= wb_data;
                    end
                end

                if (pop) begin
                    vld_q[head_q] <= 1'b0;
                    head_q        <= next_ptr(head_q);
                end

                // A push never targets the popped slot: push needs count<DEPTH,
                // and tail==head with count>0 only happens when full.
                if (push) begin
                    vld_q[tail_q] <= 1'b1;
                    ctl_q[tail_q] <= in_ctl;
                    rs1_q[tail_q] <= in_rs1;
                    rs2_q[tail_q] <= in_rs2;
                    rd1_q[tail_q] <= (wb_hit && in_rs1 == wb_rd) ? wb_data : in_rd1;
                    rd2_q[tail_q] <= (wb_hit && in_rs2 == wb_rd) ? wb_data : in_rd2;
                    tail_q        <= next_ptr(tail_q);
                end

                case ({push, pop})
                    2'b10:   count_q <= count_q + 3'd1;
                    2'b01:   count_q <= count_q - 3'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_buffer.sv
// Self-checking bench for id_ex_pipe_buffer: directed vector table, hand sequences
// for throughput and bubble saturation, then random traffic against a queue model.
module tb_id_ex_pipe_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush, wb_we;
    logic [95:0] in_ctl;
    logic [4:0]  in_rs1, in_rs2, wb_rd;
    logic [31:0] in_rd1, in_rd2, wb_data;

    logic        in_ready, out_valid;
    logic [95:0] out_ctl;
    logic [4:0]  out_rs1, out_rs2;
    logic [31:0] out_rd1, out_rd2;
    logic [2:0]  count;
    logic [15:0] bubble_cnt;

    logic        n_in_ready, n_out_valid;
    logic [95:0] n_out_ctl;
    logic [4:0]  n_out_rs1, n_out_rs2;
    logic [31:0] n_out_rd1, n_out_rd2;
    logic [2:0]  n_count;
    logic [3:0]  n_bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctl(in_ctl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .count(count), .bubble_cnt(bubble_cnt)
    );

    // Second instance with a 4-bit bubble counter to exercise saturation.
    id_ex_pipe_buffer #(.DEPTH(DEPTH), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_ctl(in_ctl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_ctl(n_out_ctl),
        .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_rd1(n_out_rd1), .out_rd2(n_out_rd2),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .count(n_count), .bubble_cnt(n_bubble_cnt)
    );

    typedef struct {
        logic [95:0] ctl;
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_bub, m_bub_n;

    typedef struct {
        logic        rst, iv, ordy, fl, we;
        logic [95:0] ctl;
        logic [4:0]  rs1, rs2, wrd;
        logic [31:0] rd1, rd2, wdat;
        logic        e_valid;
        logic [95:0] e_ctl;
        logic [31:0] e_rd1, e_rd2;
        logic [2:0]  e_count;
        logic        e_ir;
    } vec_t;

    function automatic vec_t mk(
        input logic r, iv, ordy, fl, we, input logic [95:0] c,
        input logic [4:0] s1, s2, wr, input logic [31:0] d1, d2, wd,
        input logic ev, input logic [95:0] ec, input logic [31:0] e1, e2,
        input logic [2:0] ecnt, input logic eir);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.fl = fl; v.we = we; v.ctl = c;
        v.rs1 = s1; v.rs2 = s2; v.wrd = wr; v.rd1 = d1; v.rd2 = d2; v.wdat = wd;
        v.e_valid = ev; v.e_ctl = ec; v.e_rd1 = e1; v.e_rd2 = e2;
        v.e_count = ecnt; v.e_ir = eir;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; in_valid = v.iv; out_ready = v.ordy; flush = v.fl; wb_we = v.we;
        in_ctl = v.ctl; in_rs1 = v.rs1; in_rs2 = v.rs2; wb_rd = v.wrd;
        in_rd1 = v.rd1; in_rd2 = v.rd2; wb_data = v.wdat;
    endtask

    // Reference model: a queue of instructions updated once per clock edge.
    task automatic model_edge();
        ent_t e;
        bit   mv, mpush;
        if (rst) begin
            mq.delete();
            m_bub = 0;
            m_bub_n = 0;
            return;
        end
        mv = (mq.size() != 0);
        if (out_ready && !mv) begin
            if (m_bub < 65535) m_bub++;
            if (m_bub_n < 15) m_bub_n++;
        end
        if (flush) begin
            mq.delete();
            return;
        end
        mpush = in_valid && (mq.size() < DEPTH);
        if (mv && out_ready) mq.delete(0);
        if (wb_we && wb_rd != 0) begin
            foreach (mq[i]) begin
                if (mq[i].rs1 == wb_rd) mq[i].rd1 = wb_data;
                if (mq[i].rs2 == wb_rd) mq[i].rd2 = wb_data;
            end
        end
        if (mpush) begin
            e.ctl = in_ctl; e.rs1 = in_rs1; e.rs2 = in_rs2;
            e.rd1 = (wb_we && wb_rd != 0 && in_rs1 == wb_rd) ? wb_data : in_rd1;
            e.rd2 = (wb_we && wb_rd != 0 && in_rs2 == wb_rd) ? wb_data : in_rd2;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        ent_t h;
        bit   v;
        v = (mq.size() != 0);
        h = '{ctl: '0, rs1: '0, rs2: '0, rd1: '0, rd2: '0};
        if (v) h = mq[0];
        check({tag, ".out_valid"}, 128'(out_valid), 128'(v));
        check({tag, ".out_ctl"}, 128'(out_ctl), 128'(h.ctl));
        check({tag, ".out_rs1"}, 128'(out_rs1), 128'(h.rs1));
        check({tag, ".out_rs2"}, 128'(out_rs2), 128'(h.rs2));
        check({tag, ".out_rd1"}, 128'(out_rd1), 128'(h.rd1));
        check({tag, ".out_rd2"}, 128'(out_rd2), 128'(h.rd2));
        check({tag, ".count"}, 128'(count), 128'(mq.size()));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(!rst && mq.size() < DEPTH));
        check({tag, ".bubble"}, 128'(bubble_cnt), 128'(m_bub));
        check({tag, ".bubble_n"}, 128'(n_bubble_cnt), 128'(m_bub_n));
    endtask

    vec_t vt[$];

    initial begin
        //      rst iv or fl we ctl   rs1 rs2 wrd rd1     rd2    wdata     ev e_ctl e_rd1   e_rd2  cnt ir
        vt.push_back(mk(1, 0, 0, 0, 0, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 0));
        vt.push_back(mk(0, 1, 1, 0, 0, 96'hA5, 3, 0, 0, 32'h11,  32'h0,  32'h0,    1, 96'hA5, 32'h11,   32'h0,  1, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 96'h1,  1, 2, 0, 32'h101, 32'h102, 32'h0,   1, 96'h1,  32'h101,  32'h102, 1, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 96'h2,  1, 2, 0, 32'h201, 32'h202, 32'h0,   1, 96'h1,  32'h101,  32'h102, 2, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 96'h3,  1, 2, 0, 32'h301, 32'h302, 32'h0,   1, 96'h1,  32'h101,  32'h102, 2, 0));
        vt.push_back(mk(0, 1, 1, 0, 0, 96'h3,  1, 2, 0, 32'h301, 32'h302, 32'h0,   1, 96'h2,  32'h201,  32'h202, 1, 1));
        vt.push_back(mk(0, 1, 1, 0, 0, 96'h3,  1, 2, 0, 32'h301, 32'h302, 32'h0,   1, 96'h3,  32'h301,  32'h302, 1, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 96'h55, 5, 6, 0, 32'h0,   32'h66, 32'h0,    1, 96'h55, 32'h0,    32'h66, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 96'h0,  0, 0, 5, 32'h0,   32'h0,  32'hDEAD, 1, 96'h55, 32'hDEAD, 32'h66, 1, 1));
        vt.push_back(mk(0, 1, 1, 0, 1, 96'h60, 0, 0, 0, 32'h77,  32'h88, 32'hBEEF, 1, 96'h60, 32'h77,   32'h88, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'hBEEF, 1, 96'h60, 32'h77,   32'h88, 1, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 1));
        vt.push_back(mk(0, 1, 0, 0, 1, 96'h70, 1, 7, 7, 32'h10,  32'h99, 32'h42,   1, 96'h70, 32'h10,   32'h42, 1, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 96'h71, 2, 3, 0, 32'h20,  32'h30, 32'h0,    1, 96'h70, 32'h10,   32'h42, 2, 0));
        vt.push_back(mk(0, 1, 1, 1, 0, 96'h72, 1, 1, 0, 32'h1,   32'h1,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 96'h0,  0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 96'h0,  32'h0,    32'h0,  0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            tick();
            check($sformatf("vec%0d.valid", i), 128'(out_valid), 128'(vt[i].e_valid));
            check($sformatf("vec%0d.ctl", i), 128'(out_ctl), 128'(vt[i].e_ctl));
            check($sformatf("vec%0d.rd1", i), 128'(out_rd1), 128'(vt[i].e_rd1));
            check($sformatf("vec%0d.rd2", i), 128'(out_rd2), 128'(vt[i].e_rd2));
            check($sformatf("vec%0d.count", i), 128'(count), 128'(vt[i].e_count));
            check($sformatf("vec%0d.in_ready", i), 128'(in_ready), 128'(vt[i].e_ir));
            check_all($sformatf("vec%0d.model", i));
        end

        // Streaming: one instruction per cycle with DEPTH>=2.
        drive(mk(0, 0, 1, 0, 0, 96'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 96'h0, 32'h0, 32'h0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_ctl   = 96'h100 + 96'(k);
            tick();
            check($sformatf("stream%0d.ctl", k), 128'(out_ctl), 128'(96'h100 + 96'(k)));
            check($sformatf("stream%0d.count", k), 128'(count), 128'(1));
        end
        in_valid = 1'b0;
        tick();
        check_all("stream.drain");

        // Bubble counter: 10 idle ready cycles, then saturation of the 4-bit copy.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("bubble10", 128'(bubble_cnt), 128'(10));
        for (int k = 0; k < 10; k++) tick();
        check("bubble20", 128'(bubble_cnt), 128'(20));
        check("bubble_sat", 128'(n_bubble_cnt), 128'(4'hF));
        check_all("bubble.model");

        // Random traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_we     = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            in_ctl    = {$urandom, $urandom, $urandom};
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd1    = $urandom;
            in_rd2    = $urandom;
            tick();
            check_all($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
